mem_reinit_ctrl: RTL and testbench

- Sequencer in front of one simple-dual-port block RAM instance (WID_MEM x DEPTH_MEM, 1-cycle registered read).
- Fill mode: reloads the entire RAM from a valid/ready word stream.
- Checksum mode: reads the RAM back and produces a 32-bit checksum.
- When idle, a user port passes through to the RAM. This block is the only master of the RAM ports.

---
 rtl/mem_reinit_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mem_reinit_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reinit_ctrl.sv
// -----------------------------------------------------------------------------
// mem_reinit_ctrl
// Sequencer that owns the ports of one simple-dual-port block RAM
// (WID_MEM x DEPTH_MEM, 1-cycle registered read).
//   - IDLE     : user port passes straight through to the RAM.
//   - FILL     : reloads every RAM word from a valid/ready stream.
//   - READ/DRAIN: reads the whole RAM back and sums it into a 32-bit checksum.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start, mode       one-cycle start pulse (IDLE only); mode 0 = fill, 1 = checksum
//   busy, done        sequence in progress / one-cycle completion pulse
//   checksum          result of the last checksum run
//   in_valid/in_data/in_ready   fill word stream
//   user_raddr/user_waddr/user_din/user_we/user_grant   user RAM port (IDLE only)
//   mem_raddr/mem_waddr/mem_din/mem_we/mem_dout         RAM connections
// -----------------------------------------------------------------------------
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [31:0]        checksum,
  input  logic               in_valid,
  input  logic [WID_MEM-1:0] in_data,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  user_raddr,
  input  logic [ADDR_W-1:0]  user_waddr,
  input  logic [WID_MEM-1:0] user_din,
  input  logic               user_we,
  output logic               user_grant,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Zero-extend a RAM word to the 32-bit accumulator width (works for WID_MEM=32 too).
  function automatic logic [31:0] zext_word(input logic [WID_MEM-1:0] d);
    logic [31:0] v;
    v = 32'd0;
    v[WID_MEM-1:0] = d;
    return v;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_acc;
  logic [31:0]         r_checksum;
  logic                r_fill_done;
  logic                w_last;
  logic                w_fill_hs;
  logic [31:0]         w_acc_sum;

  assign w_last    = (r_addr == LP_LAST);
  // in_ready is 1 throughout FILL, so a valid word is always a handshake there.
  assign w_fill_hs = (r_state == ST_FILL) && in_valid;
  assign w_acc_sum = r_acc + zext_word(mem_dout);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = mode ? ST_READ : ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_fill_hs && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_READ: begin
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address counter, accumulator, checksum result and fill-complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_acc       <= 32'd0;
      r_checksum  <= 32'd0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= w_fill_hs && w_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr <= '0;
            if (mode) begin
              r_acc <= 32'd0;
            end
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            r_addr <= r_addr + LP_ONE;
          end
        end
        ST_READ: begin
          r_addr <= r_addr + LP_ONE;
          // The first READ cycle has no read data back yet.
          if (r_addr != '0) begin
            r_acc <= w_acc_sum;
          end
        end
        ST_DRAIN: begin
          r_acc      <= w_acc_sum;
          r_checksum <= w_acc_sum;
        end
        default: begin
          r_addr <= '0;
        end
      endcase
    end
  end

  // Output decode: RAM port mux, handshake and status.
  always_comb begin
    mem_raddr  = user_raddr;
    mem_waddr  = user_waddr;
    mem_din    = user_din;
    mem_we     = 1'b0;
    in_ready   = 1'b0;
    user_grant = 1'b0;
    busy       = 1'b0;
    done       = r_fill_done;
    checksum   = r_checksum;
    case (r_state)
      ST_IDLE: begin
        user_grant = 1'b1;
        // Keep the RAM write-protected while reset is held.
        mem_we     = user_we && reset;
      end
      ST_FILL: begin
        busy      = 1'b1;
        in_ready  = 1'b1;
        mem_raddr = r_addr;
        mem_waddr = r_addr;
        mem_din   = in_data;
        mem_we    = in_valid;
      end
      ST_READ: begin
        busy      = 1'b1;
        mem_raddr = r_addr;
        mem_waddr = r_addr;
        mem_din   = '0;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        mem_raddr = r_addr;
        mem_waddr = r_addr;
        mem_din   = '0;
        // Final value is already visible in the cycle done is raised.
        checksum  = w_acc_sum;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
module tb_mem_reinit_ctrl;

  localparam int WID   = 16;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic            busy;
  logic            done;
  logic [31:0]     checksum;
  logic            in_valid;
  logic [WID-1:0]  in_data;
  logic            in_ready;
  logic [AW-1:0]   user_raddr;
  logic [AW-1:0]   user_waddr;
  logic [WID-1:0]  user_din;
  logic            user_we;
  logic            user_grant;
  logic [AW-1:0]   mem_raddr;
  logic [AW-1:0]   mem_waddr;
  logic [WID-1:0]  mem_din;
  logic            mem_we;
  logic [WID-1:0]  mem_dout;

  logic [WID-1:0]  ram     [DEPTH];
  logic [WID-1:0]  ref_mem [DEPTH];
  logic [WID-1:0]  stim    [DEPTH];

  int n_vec = 0;
  int n_bad = 0;

  mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .checksum(checksum),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .user_raddr(user_raddr), .user_waddr(user_waddr), .user_din(user_din),
    .user_we(user_we), .user_grant(user_grant),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Block RAM: synchronous write, 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < DEPTH; i++) s = s + {16'd0, ref_mem[i]};
    return s;
  endfunction

  function automatic int mem_diff();
    int d;
    d = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // stall_mode: 0 = none, 1 = every third cycle, 2 = random
  task automatic do_fill(input int stall_mode, input bit lockout);
    int idx, cyc, busy_cyc, err_rdy, err_stall, dones;
    bit vld;
    idx = 0; cyc = 0; busy_cyc = 0; err_rdy = 0; err_stall = 0; dones = 0;
    @(posedge clk); #1 start = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    while (idx < DEPTH && cyc < 3 * DEPTH) begin
      case (stall_mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 3) != 2;
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = vld;
      in_data  = stim[idx];
      if (lockout && cyc == 10) begin
        user_we = 1'b1; user_waddr = '0; user_din = 16'h1234; start = 1'b1; mode = 1'b1;
      end
      @(negedge clk);
      if (busy) busy_cyc++;
      if (!in_ready) err_rdy++;
      if (!vld && mem_we) err_stall++;
      if (done) dones++;
      if (lockout && cyc == 10) chk("lockout_grant", {31'd0, user_grant}, 32'd0);
      @(posedge clk); #1;
      if (lockout && cyc == 10) begin
        user_we = 1'b0; start = 1'b0; mode = 1'b0;
      end
      if (vld) idx++;
      cyc++;
    end
    // Back in IDLE: a valid word offered now must not be accepted.
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    @(negedge clk);
    chk("fill_done", {31'd0, done}, 32'd1);
    chk("fill_busy_end", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_no_write", {31'd0, mem_we}, 32'd0);
    chk("fill_busy_cycles", 32'(busy_cyc), 32'(cyc));
    chk("fill_ready_err", 32'(err_rdy), 32'd0);
    chk("fill_stall_write", 32'(err_stall), 32'd0);
    chk("fill_early_done", 32'(dones), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("fill_done_once", {31'd0, done}, 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = stim[i];
    chk("fill_contents", 32'(mem_diff()), 32'd0);
  endtask

  task automatic do_checksum(input logic [31:0] exp);
    int n, err_we, err_grant;
    n = 0; err_we = 0; err_grant = 0;
    @(posedge clk); #1 start = 1'b1; mode = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = 1'b0;
    user_we = 1'b1; user_waddr = AW'($urandom_range(0, DEPTH - 1)); user_din = WID'($urandom);
    do begin
      @(negedge clk);
      n++;
      if (mem_we) err_we++;
      if (user_grant) err_grant++;
      if (n == 50) begin
        start = 1'b1; mode = 1'b0;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < DEPTH + 50);
    start = 1'b0;
    chk("cks_latency", 32'(n), 32'(DEPTH + 1));
    chk("cks_value", checksum, exp);
    chk("cks_busy_at_done", {31'd0, busy}, 32'd1);
    chk("cks_user_we_blocked", 32'(err_we), 32'd0);
    chk("cks_grant_low", 32'(err_grant), 32'd0);
    @(posedge clk); #1 user_we = 1'b0;
    @(negedge clk);
    chk("cks_busy_after", {31'd0, busy}, 32'd0);
    chk("cks_done_once", {31'd0, done}, 32'd0);
    chk("cks_held", checksum, exp);
  endtask

  initial begin
    int n;
    int dones;
    logic [AW-1:0] a;
    logic [WID-1:0] d;

    reset = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    user_raddr = '0; user_waddr = '0; user_din = '0; user_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk); reset = 1'b1; user_we = 1'b0;
    @(negedge clk);
    chk("idle_grant", {31'd0, user_grant}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Idle passthrough
    @(posedge clk); #1 user_we = 1'b1; user_waddr = 12'd5; user_din = 16'hBEEF;
    @(posedge clk); #1 user_we = 1'b0; user_raddr = 12'd5;
    @(posedge clk); #1;
    chk("pass_read", {16'd0, mem_dout}, 32'h0000BEEF);
    chk("pass_grant", {31'd0, user_grant}, 32'd1);

    // Random user writes and readbacks
    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      d = WID'($urandom);
      user_we = 1'b1; user_waddr = a; user_din = d;
      @(posedge clk); #1 user_we = 1'b0; user_raddr = a;
      @(posedge clk); #1;
      chk("rand_pass_read", {16'd0, mem_dout}, {16'd0, d});
    end

    // Full fill with value = index, then checksum
    for (int i = 0; i < DEPTH; i++) stim[i] = WID'(i);
    do_fill(0, 1'b0);
    do_checksum(32'h007FF800);

    // All-ones fill with user write / start attempted mid-fill
    for (int i = 0; i < DEPTH; i++) stim[i] = 16'hFFFF;
    do_fill(0, 1'b1);
    do_checksum(32'h0FFFF000);

    // Stalled fill (every third cycle idle), same index data
    for (int i = 0; i < DEPTH; i++) stim[i] = WID'(i);
    do_fill(1, 1'b0);
    do_checksum(ref_sum());

    // Random data with random stalls
    for (int i = 0; i < DEPTH; i++) stim[i] = WID'($urandom);
    do_fill(2, 1'b0);
    do_checksum(ref_sum());

    // Reset in the middle of a checksum run
    @(posedge clk); #1 start = 1'b1; mode = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && mem_raddr == 12'd100) && n < 500);
    chk("mid_reach_addr100", {20'd0, mem_raddr}, 32'd100);
    reset = 1'b0; user_we = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_checksum", checksum, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; user_we = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    do_checksum(ref_sum());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
